eth_arp_recv: RTL and testbench
===============================

# eth_arp_recv

Receive-side ARP parser for the 8-bit GMII-style Ethernet path, the counterpart of the ARP frame transmitter. Consumes raw received bytes including preamble, SFD and FCS, validates framing, addressing, ARP header fields and CRC-32, and reports the sender MAC/IP plus request/reply type. Its done pulse drives the top-level ARP control that fires `arp_ack_trig` (reply to a request) or updates the peer MAC table.

## Interface
- `LOCAL_MAC`, 48'h00_0a_35_01_fe_c0, own MAC; unicast frames must match it.
- `LOCAL_IP`, 32'hc0_a8_01_0a, own IP (192.168.1.10); ARP target IP must match it.
- `clk`  in  1  receive byte clock; one byte per cycle when `rx_dv`=1.
- `rst`  in  1  reset, asynchronous, active-high.
- `rx_dv`  in  1  receive data valid, high for whole frame incl. preamble.
- `rx_data`  in  8  received byte.
- `arp_rx_done`  out  1  one-cycle pulse: valid ARP frame for us received.
- `arp_rx_type`  out  1  0 = request (opcode 1), 1 = reply (opcode 2); valid with/after done.
- `arp_src_mac`  out  48  sender hardware address of last good frame.
- `arp_src_ip`  out  32  sender protocol address of last good frame.
- `crc_err`  out  1  one-cycle pulse: frame passed all field checks but FCS bad.

## Operation
- States: IDLE, PREAMBLE, ETH_HEAD, ARP_DATA, TAIL, RX_END.
- IDLE: `rx_dv`=1 and `rx_data`=8'h55 -> PREAMBLE (byte count 1); `rx_dv`=1 with other byte -> RX_END.
- PREAMBLE: bytes 2..7 must be 8'h55, byte 8 must be 8'hd5 -> ETH_HEAD; any mismatch -> RX_END.
- ETH_HEAD (14 bytes): dst MAC must equal 48'hffffffffffff or `LOCAL_MAC`; EtherType bytes 12..13 must be 8'h08, 8'h06. Mismatch -> RX_END at end of field check.
- ARP_DATA (28 bytes): htype 16'h0001, ptype 16'h0800, hlen 8'h06, plen 8'h04, opcode 16'h0001 or 16'h0002; sender MAC (bytes 8..13) and sender IP (14..17) captured into shadow regs; target MAC ignored; target IP (24..27) must equal `LOCAL_IP`. Mismatch -> RX_END.
- TAIL: consume padding and 4 FCS bytes until `rx_dv`=0. Bytes after SFD must total >= 46 (14+28+4); fewer -> drop silently.
- RX_END: wait for `rx_dv`=0, then IDLE. No outputs asserted.
- CRC: LSB-first (reflected) CRC-32, poly 0xEDB88320, init 32'hFFFFFFFF, cleared at SFD, updated on every byte from dst MAC through last FCS byte. Good frame leaves register = 32'hDEBB20E3.
- On `rx_dv` falling in TAIL: residue good -> commit shadow regs to `arp_src_mac`/`arp_src_ip`/`arp_rx_type`, pulse `arp_rx_done`; residue bad -> pulse `crc_err`, outputs unchanged.
- `rx_dv` falling in PREAMBLE/ETH_HEAD/ARP_DATA -> IDLE, no pulse.
- Back-to-back frames: frame may start in the cycle after `rx_dv`=0 sampled; IDLE decision uses that cycle.

## Timing
- All outputs registered. Reset: `arp_rx_done`=0, `crc_err`=0, `arp_rx_type`=0, `arp_src_mac`=0, `arp_src_ip`=0, state IDLE, counters 0, CRC 32'hFFFFFFFF.
- `arp_rx_done`/`crc_err` assert in the cycle after the first `rx_dv`=0 sample ending the frame; high exactly one cycle; mutually exclusive.
- `arp_src_mac`, `arp_src_ip`, `arp_rx_type` change only in the `arp_rx_done` cycle and hold until the next one.
- Byte counter 6 bits, reset on each state entry; never wraps (TAIL saturates at 63).
- `rst` mid-frame: immediate return to reset values; remainder of frame handled from IDLE (non-0x55 byte -> RX_END).

## Structure
- Shared package `eth_pkg`: `ETH_PREAMBLE` 8'h55, `ETH_SFD` 8'hd5, `ETH_TYPE_ARP` 16'h0806, `ARP_HTYPE_ETH`, `ARP_PTYPE_IPV4`, `ARP_OP_REQ`/`ARP_OP_REPLY`, `CRC32_RESIDUE` 32'hDEBB20E3, receive state enum.
- One sub-module: `crc32_d8` (clk, rst, crc_en, crc_clr, data[7:0], crc_data[31:0]), single-cycle byte-wise update; reusable by the transmit path.

## Test plan
- Broadcast ARP request, sender 00:11:22:33:44:55 / 192.168.1.100, target 192.168.1.10, 18 pad bytes, correct FCS -> one `arp_rx_done`, `arp_rx_type`=0, `arp_src_mac`=48'h001122334455, `arp_src_ip`=32'hc0a80164.
- Unicast reply to `LOCAL_MAC`, opcode 2, sender 192.168.1.1 -> done, type 1, `arp_src_ip`=32'hc0a80101; dst MAC 00:0a:35:01:fe:c1 -> no pulse.
- Target IP 192.168.1.11 or EtherType 0x0800 or 7th preamble byte 0x54 -> no pulse, outputs hold previous values.
- Valid frame with last FCS byte XOR 0x01 -> `crc_err` one cycle, no done, outputs unchanged.
- `rx_dv` dropped after ARP byte 10, then immediate good frame -> no pulse for first, done for second.
- `rst` pulsed during ETH_HEAD -> outputs zero, no pulse for that frame; next good frame reports done.

Source files
------------

// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet/ARP constants, receive state enum and the CRC-32 byte update.
package eth_pkg;
  localparam logic [7:0]  ETH_PREAMBLE   = 8'h55;
  localparam logic [7:0]  ETH_SFD        = 8'hd5;
  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'h06;
  localparam logic [7:0]  ARP_PLEN       = 8'h04;
  localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;
  localparam logic [31:0] CRC32_POLY     = 32'hedb88320;
  localparam logic [31:0] CRC32_INIT     = 32'hffffffff;
  localparam logic [31:0] CRC32_RESIDUE  = 32'hdebb20e3;
  typedef enum logic [2:0] {
    ST_IDLE, ST_PREAMBLE, ST_ETH_HEAD, ST_ARP_DATA, ST_TAIL, ST_RX_END
  } rx_state_t;
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) c = c[0] ? (c >> 1) ^ CRC32_POLY : c >> 1;
    return c;
  endfunction
endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: reflected CRC-32, one byte per cycle, no final inversion.
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        crc_en,
  input  logic        crc_clr,
  input  logic [7:0]  data,
  output logic [31:0] crc_data
);
  always_ff @(posedge clk or posedge rst)
    if (rst) crc_data <= CRC32_INIT;
    else if (crc_clr) crc_data <= CRC32_INIT;
    else if (crc_en) crc_data <= crc32_byte(crc_data, data);
endmodule

// File: rtl/eth_arp_recv.sv
// eth_arp_recv: parses received GMII bytes, validates an ARP frame addressed to us
// and reports the sender MAC/IP and request/reply type.
module eth_arp_recv
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h000a3501fec0,
  parameter logic [31:0] LOCAL_IP  = 32'hc0a8010a
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic        arp_rx_done,
  output logic        arp_rx_type,
  output logic [47:0] arp_src_mac,
  output logic [31:0] arp_src_ip,
  output logic        crc_err
);
  rx_state_t   state;
  logic [5:0]  cnt;
  logic [39:0] sr;
  logic [47:0] sh_mac, w48;
  logic [31:0] sh_ip, w32, crc_data;
  logic [15:0] w16;
  logic        sh_type, eth_bad, arp_bad;
  // Multi-byte fields are checked on their last byte against the byte history.
  assign w48 = {sr, rx_data};
  assign w32 = {sr[23:0], rx_data};
  assign w16 = {sr[7:0], rx_data};
  always_comb begin
    eth_bad = (cnt == 6'd5 && w48 != 48'hffffffffffff && w48 != LOCAL_MAC) ||
              (cnt == 6'd13 && w16 != ETH_TYPE_ARP);
    arp_bad = (cnt == 6'd1 && w16 != ARP_HTYPE_ETH) ||
              (cnt == 6'd3 && w16 != ARP_PTYPE_IPV4) ||
              (cnt == 6'd4 && rx_data != ARP_HLEN) ||
              (cnt == 6'd5 && rx_data != ARP_PLEN) ||
              (cnt == 6'd7 && w16 != ARP_OP_REQ && w16 != ARP_OP_REPLY) ||
              (cnt == 6'd27 && w32 != LOCAL_IP);
  end
  crc32_d8 u_crc (
    .clk      (clk),
    .rst      (rst),
    .crc_en   (rx_dv && (state == ST_ETH_HEAD || state == ST_ARP_DATA || state == ST_TAIL)),
    .crc_clr  (state == ST_PREAMBLE),
    .data     (rx_data),
    .crc_data (crc_data)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      sr          <= '0;
      sh_mac      <= '0;
      sh_ip       <= '0;
      sh_type     <= 1'b0;
      arp_rx_done <= 1'b0;
      arp_rx_type <= 1'b0;
      arp_src_mac <= '0;
      arp_src_ip  <= '0;
      crc_err     <= 1'b0;
    end else begin
      arp_rx_done <= 1'b0;
      crc_err     <= 1'b0;
      cnt         <= cnt + {5'd0, cnt != 6'd63};
      if (rx_dv) sr <= {sr[31:0], rx_data};
      case (state)
        ST_IDLE:
          if (rx_dv) begin
            state <= (rx_data == ETH_PREAMBLE) ? ST_PREAMBLE : ST_RX_END;
            cnt   <= {5'd0, rx_data == ETH_PREAMBLE};
          end else cnt <= '0;
        ST_PREAMBLE:
          if (!rx_dv) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (cnt == 6'd7 && rx_data == ETH_SFD) begin
            state <= ST_ETH_HEAD;
            cnt   <= '0;
          end else if (cnt == 6'd7 || rx_data != ETH_PREAMBLE) begin
            state <= ST_RX_END;
            cnt   <= '0;
          end
        ST_ETH_HEAD:
          if (!rx_dv || eth_bad || cnt == 6'd13) begin
            state <= !rx_dv ? ST_IDLE : eth_bad ? ST_RX_END : ST_ARP_DATA;
            cnt   <= '0;
          end
        ST_ARP_DATA: begin
          if (cnt == 6'd7) sh_type <= (w16 == ARP_OP_REPLY);
          if (cnt == 6'd13) sh_mac <= w48;
          if (cnt == 6'd17) sh_ip <= w32;
          if (!rx_dv || arp_bad || cnt == 6'd27) begin
            state <= !rx_dv ? ST_IDLE : arp_bad ? ST_RX_END : ST_TAIL;
            cnt   <= '0;
          end
        end
        ST_TAIL:
          // 42 header bytes already seen, so 4 more reach the 46-byte minimum.
          if (!rx_dv) begin
            state <= ST_IDLE;
            cnt   <= '0;
            if (cnt >= 6'd4) begin
              arp_rx_done <= (crc_data == CRC32_RESIDUE);
              crc_err     <= (crc_data != CRC32_RESIDUE);
              if (crc_data == CRC32_RESIDUE) begin
                arp_src_mac <= sh_mac;
                arp_src_ip  <= sh_ip;
                arp_rx_type <= sh_type;
              end
            end
          end
        ST_RX_END:
          if (!rx_dv) begin
            state <= ST_IDLE;
            cnt   <= '0;
          end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
endmodule

// File: tb/tb_eth_arp_recv.sv
// tb_eth_arp_recv: scoreboard bench driving whole Ethernet/ARP frames into eth_arp_recv.
module tb_eth_arp_recv;
  localparam logic [47:0] LMAC = 48'h000a3501fec0;
  localparam logic [47:0] BC   = 48'hffffffffffff;
  localparam logic [31:0] LIP  = 32'hc0a8010a;
  typedef struct {
    logic        kind;
    logic [47:0] mac;
    logic [31:0] ip;
    logic        typ;
  } exp_t;
  logic        clk = 1'b0, rst = 1'b1, rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        arp_rx_done, arp_rx_type, crc_err;
  logic [47:0] arp_src_mac;
  logic [31:0] arp_src_ip;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [7:0]  frm[$];
  logic [47:0] m_mac = '0, b_mac;
  logic [31:0] m_ip = '0, b_ip;
  logic        m_typ = 1'b0, b_typ;
  int          n_chk = 0, n_bad = 0;

  eth_arp_recv dut (
    .clk         (clk),
    .rst         (rst),
    .rx_dv       (rx_dv),
    .rx_data     (rx_data),
    .arp_rx_done (arp_rx_done),
    .arp_rx_type (arp_rx_type),
    .arp_src_mac (arp_src_mac),
    .arp_src_ip  (arp_src_ip),
    .crc_err     (crc_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic build(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] op,
                       input logic [47:0] smac, input logic [31:0] sip, input logic [31:0] tip,
                       input int npad, input logic [7:0] fx, input logic [7:0] p7);
    logic [7:0]  p[$];
    logic [31:0] c;
    frm.delete();
    for (int i = 0; i < 7; i++) frm.push_back(i == 6 ? p7 : 8'h55);
    frm.push_back(8'hd5);
    for (int i = 5; i >= 0; i--) p.push_back(dst[8*i+:8]);
    for (int i = 5; i >= 0; i--) p.push_back(smac[8*i+:8]);
    p.push_back(et[15:8]); p.push_back(et[7:0]);
    p.push_back(8'h00); p.push_back(8'h01); p.push_back(8'h08); p.push_back(8'h00);
    p.push_back(8'h06); p.push_back(8'h04);
    p.push_back(op[15:8]); p.push_back(op[7:0]);
    for (int i = 5; i >= 0; i--) p.push_back(smac[8*i+:8]);
    for (int i = 3; i >= 0; i--) p.push_back(sip[8*i+:8]);
    for (int i = 0; i < 6; i++) p.push_back(8'h00);
    for (int i = 3; i >= 0; i--) p.push_back(tip[8*i+:8]);
    for (int i = 0; i < npad; i++) p.push_back(8'h00);
    c = 32'hffffffff;
    foreach (p[i]) begin
      c ^= {24'd0, p[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? (c >> 1) ^ 32'hedb88320 : c >> 1;
    end
    c = ~c;
    foreach (p[i]) frm.push_back(p[i]);
    frm.push_back(c[7:0]); frm.push_back(c[15:8]); frm.push_back(c[23:16]);
    frm.push_back(c[31:24] ^ fx);
    b_mac = smac;
    b_ip  = sip;
    b_typ = (op == 16'h0002);
  endtask

  // pulse: 2'b10 expects done, 2'b01 expects crc_err, 2'b00 expects nothing.
  task automatic send(input int cut, input int rst_at, input logic [1:0] pulse);
    exp_t e;
    int   n;
    n = (cut > 0 && cut < frm.size()) ? cut : frm.size();
    if (pulse == 2'b10) begin
      m_mac = b_mac; m_ip = b_ip; m_typ = b_typ;
    end
    e.kind = pulse[0]; e.mac = m_mac; e.ip = m_ip; e.typ = m_typ;
    if (pulse != 2'b00) sb.push_back(e);
    for (int i = 0; i < n; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        #1;
        chk("rst_mac", arp_src_mac, 0);
        chk("rst_ip", arp_src_ip, 0);
        chk("rst_type", arp_rx_type, 0);
        m_mac = '0; m_ip = '0; m_typ = 1'b0;
        #2 rst = 1'b0;
      end
      rx_dv = 1'b1;
      rx_data = frm[i];
      @(posedge clk); #1;
    end
    rx_dv = 1'b0;
    rx_data = 8'h00;
    @(posedge clk); #1;
    chk("pulse_timing", {arp_rx_done, crc_err}, pulse);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
    chk("hold_mac", arp_src_mac, m_mac);
    chk("hold_ip", arp_src_ip, m_ip);
    chk("hold_type", arp_rx_type, m_typ);
  endtask

  always @(negedge clk)
    if (!rst && (arp_rx_done || crc_err)) begin
      if (sb.size() == 0) chk("spurious_pulse", {arp_rx_done, crc_err}, 2'b00);
      else begin
        mon_e = sb.pop_front();
        chk("pulse_kind", {arp_rx_done, crc_err}, mon_e.kind ? 2'b01 : 2'b10);
        if (!mon_e.kind) begin
          chk("sb_mac", arp_src_mac, mon_e.mac);
          chk("sb_ip", arp_src_ip, mon_e.ip);
          chk("sb_type", arp_rx_type, mon_e.typ);
        end
      end
    end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", arp_rx_done, 0);
    chk("reset_crc_err", crc_err, 0);
    chk("reset_type", arp_rx_type, 0);
    chk("reset_mac", arp_src_mac, 0);
    chk("reset_ip", arp_src_ip, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    build(BC, 16'h0806, 16'h0001, 48'h001122334455, 32'hc0a80164, LIP, 18, 8'h00, 8'h55);
    send(0, -1, 2'b10); settle();
    build(LMAC, 16'h0806, 16'h0002, 48'h665544332211, 32'hc0a80101, LIP, 18, 8'h00, 8'h55);
    send(0, -1, 2'b10); settle();
    build(LMAC + 48'd1, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0f, 32'hc0a80105, LIP, 18, 8'h00, 8'h55);
    send(0, -1, 2'b00); settle();
    build(BC, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0f, 32'hc0a80105, LIP + 32'd1, 18, 8'h00, 8'h55);
    send(0, -1, 2'b00); settle();
    build(BC, 16'h0800, 16'h0001, 48'h0a0b0c0d0e0f, 32'hc0a80105, LIP, 18, 8'h00, 8'h55);
    send(0, -1, 2'b00); settle();
    build(BC, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0f, 32'hc0a80105, LIP, 18, 8'h00, 8'h54);
    send(0, -1, 2'b00); settle();
    build(BC, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0f, 32'hc0a80105, LIP, 18, 8'h01, 8'h55);
    send(0, -1, 2'b01); settle();
    build(BC, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0f, 32'hc0a80105, LIP, 18, 8'h00, 8'h55);
    send(33, -1, 2'b00);
    build(LMAC, 16'h0806, 16'h0002, 48'h102030405060, 32'hc0a80120, LIP, 18, 8'h00, 8'h55);
    send(0, -1, 2'b10); settle();
    build(BC, 16'h0806, 16'h0001, 48'h0a0b0c0d0e0f, 32'hc0a80105, LIP, 18, 8'h00, 8'h55);
    send(0, 11, 2'b00); settle();
    build(BC, 16'h0806, 16'h0001, 48'h0c0d0e0f1011, 32'hc0a80133, LIP, 18, 8'h00, 8'h55);
    send(0, -1, 2'b10); settle();
    build(BC, 16'h0806, 16'h0002, 48'h777777777777, 32'hc0a80177, LIP, 0, 8'h00, 8'h55);
    send(0, -1, 2'b10); settle();
    build(BC, 16'h0806, 16'h0001, 48'h888888888888, 32'hc0a80188, LIP, 0, 8'h00, 8'h55);
    send(53, -1, 2'b00); settle();
    for (int k = 0; k < 4; k++) begin
      build(k[0] ? BC : LMAC, 16'h0806, 16'($urandom_range(1, 2)), {16'($urandom), 32'($urandom)},
            32'($urandom), LIP, int'($urandom_range(0, 20)), 8'h00, 8'h55);
      send(0, -1, 2'b10);
    end
    settle();
    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
